// File: rtl/tt_uart_tx_fifo_if.sv
// Byte-write / status bundle between the core logic and the UART transmit stage.
interface tt_uart_tx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ovf;
  logic          busy;
  logic          txd;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  full, empty, count, ovf, busy, txd
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output full, empty, count, ovf, busy, txd
  );
endinterface

// File: rtl/tt_uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; ena=0 freezes every register.
module tt_uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  tt_uart_tx_fifo_if.slave    bus
);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          full_c;
  logic          bit_end;
  logic          pop;
  logic          wr_acc;

  assign full_c  = (count_q == CNT_FULL);
  assign bit_end = (baud_q == BAUD_LAST);

  assign bus.full  = full_c;
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;
  assign bus.txd   = txd_q;

  // Next-state: FIFO bookkeeping, overflow flag and frame sequencing.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    wr_acc   = 1'b0;
    pop      = 1'b0;

    if (ena) begin
      wr_acc = bus.wr_en && !full_c;
      // Pop when the line is free now or becomes free at this edge.
      pop    = (count_q != '0) &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(pop);

      // Full is judged before the edge, so a same-edge pop never rescues the byte.
      if (bus.wr_en && full_c) ovf_d = 1'b1;
      else if (bus.clr_ovf)    ovf_d = 1'b0;

      baud_d = bit_end ? '0 : baud_q + BW'(1);

      case (state_q)
        ST_IDLE: begin
          baud_d = '0;
          if (pop) begin
            state_d = ST_START;
            shreg_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
            txd_d   = shreg_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = {1'b0, shreg_q[7:1]};
              txd_d   = shreg_q[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state_d = ST_START;
              shreg_d = mem_q[rd_ptr_q];
              txd_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase

      busy_d = (state_d != ST_IDLE);
    end
  end

  // State, FIFO storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_tt_uart_tx_fifo.sv
// Directed bench for tt_uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_tt_uart_tx_fifo;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FLEN  = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  tt_uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus)
  );

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle i of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int idx;
    idx = i / int'(CPB);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Walk one frame from cycle first_i, checking txd/busy every cycle; optional
  // 7-cycle ena hold at cycle hold_at and optional write on the final STOP edge.
  task automatic frame(input string tag, input logic [7:0] b, input int first_i,
                       input int hold_at, input bit wr_end, input logic [7:0] wr_byte);
    for (int i = first_i; i < FLEN; i++) begin
      check({tag, "_txd"}, 32'(bus.txd), 32'(exp_bit(b, i)));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (i == hold_at) begin
        ena = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hFF;
        for (int k = 0; k < 7; k++) begin
          tick();
          check({tag, "_hold_txd"}, 32'(bus.txd), 32'(exp_bit(b, i)));
          check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
        end
        bus.wr_en = 1'b0;
        check({tag, "_hold_cnt"}, 32'(bus.count), 32'd0);
        ena = 1'b1;
      end
      if (i == FLEN - 1 && wr_end) begin
        bus.wr_en = 1'b1;
        bus.wr_data = wr_byte;
      end
      tick();
      bus.wr_en = 1'b0;
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    tick();
    tick();
    check("rst_txd",   32'(bus.txd),   32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    rst_n = 1'b1;
    tick();

    // Single byte 0xA5: write edge N, start bit after N+1.
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("one_cnt_after_wr", 32'(bus.count), 32'd1);
    check("one_txd_idle", 32'(bus.txd), 32'd1);
    tick();
    check("one_empty_start", 32'(bus.empty), 32'd1);
    frame("one", 8'hA5, 0, -1, 1'b0, 8'h00);
    check("one_busy_end", 32'(bus.busy), 32'd0);
    check("one_txd_end", 32'(bus.txd), 32'd1);
    check("one_empty_end", 32'(bus.empty), 32'd1);

    // Burst 0x01..0x06: first pops, four fill, sixth overflows.
    bus.wr_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.wr_data = 8'(k + 1);
      tick();
      if (k == 4) begin
        check("burst_full", 32'(bus.full), 32'd1);
        check("burst_cnt4", 32'(bus.count), 32'd4);
        check("burst_ovf_pre", 32'(bus.ovf), 32'd0);
      end
      if (k == 5) begin
        check("burst_ovf", 32'(bus.ovf), 32'd1);
        check("burst_cnt_drop", 32'(bus.count), 32'd4);
      end
    end
    bus.wr_en = 1'b0;
    frame("b01", 8'h01, 4, -1, 1'b0, 8'h00);
    check("burst_cnt3", 32'(bus.count), 32'd3);
    check("burst_full_clr", 32'(bus.full), 32'd0);
    for (int k = 2; k <= 5; k++) frame("bn", 8'(k), 0, -1, 1'b0, 8'h00);
    check("burst_idle", 32'(bus.busy), 32'd0);
    check("burst_empty", 32'(bus.empty), 32'd1);
    check("burst_ovf_sticky", 32'(bus.ovf), 32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("burst_ovf_clr", 32'(bus.ovf), 32'd0);

    // Write and pop on the same STOP-end edge with count=2.
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA1;
    tick();
    bus.wr_data = 8'hA2;
    tick();
    bus.wr_data = 8'hA3;
    tick();
    bus.wr_en = 1'b0;
    check("simul_cnt_pre", 32'(bus.count), 32'd2);
    frame("s1", 8'hA1, 1, -1, 1'b1, 8'hA4);
    check("simul_cnt", 32'(bus.count), 32'd2);
    check("simul_txd", 32'(bus.txd), 32'd0);
    frame("s2", 8'hA2, 0, -1, 1'b0, 8'h00);
    frame("s3", 8'hA3, 0, -1, 1'b0, 8'h00);
    frame("s4", 8'hA4, 0, -1, 1'b0, 8'h00);
    check("simul_idle", 32'(bus.busy), 32'd0);
    check("simul_ovf", 32'(bus.ovf), 32'd0);

    // ena low for 7 cycles in DATA bit 3: frame becomes 47 cycles.
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    tick();
    frame("ena", 8'h5A, 0, 17, 1'b0, 8'h00);
    check("ena_idle", 32'(bus.busy), 32'd0);
    check("ena_txd", 32'(bus.txd), 32'd1);
    check("ena_ovf", 32'(bus.ovf), 32'd0);

    // Asynchronous reset in DATA with two bytes queued.
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h11;
    tick();
    bus.wr_data = 8'h22;
    tick();
    bus.wr_data = 8'h33;
    tick();
    bus.wr_en = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("mid_txd_pre", 32'(bus.txd), 32'(exp_bit(8'h11, 11)));
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd",   32'(bus.txd),   32'd1);
    check("mid_rst_busy",  32'(bus.busy),  32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    tick();
    frame("post", 8'h3C, 0, -1, 1'b0, 8'h00);
    check("post_idle", 32'(bus.busy), 32'd0);

    // Twelve paced bytes wrap both pointers three times.
    for (int k = 0; k < 12; k++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(k * 19 + 7);
      tick();
      bus.wr_en = 1'b0;
      tick();
      frame("wrap", 8'(k * 19 + 7), 0, -1, 1'b0, 8'h00);
      check("wrap_idle", 32'(bus.busy), 32'd0);
    end
    check("wrap_ovf", 32'(bus.ovf), 32'd0);
    check("wrap_empty", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
